// File: rtl/branch_resolve_n_pkg.sv
// rtl/branch_resolve_n_pkg.sv - shared funct3 codes and FSM state type for branch resolution
package branch_resolve_n_pkg;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

endpackage

// File: rtl/branch_cond_decode.sv
// rtl/branch_cond_decode.sv - funct3 plus comparator flags to branch condition and signed select
module branch_cond_decode
    import branch_resolve_n_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       less,
    input  logic       equal,
    output logic       cond,
    output logic       br_signed
);

    // Only the unsigned compares (BLTU/BGEU) have funct3[1] set among legal codes
    assign br_signed = ~funct3[1];

    // Map the condition code onto the comparator flags; 010/011 never branch
    always_comb begin
        cond = 1'b0;
        case (funct3)
            F3_BEQ:  cond = equal;
            F3_BNE:  cond = ~equal;
            F3_BLT:  cond = less;
            F3_BGE:  cond = ~less;
            F3_BLTU: cond = less;
            F3_BGEU: cond = ~less;
            default: cond = 1'b0;
        endcase
    end

endmodule

// File: rtl/branch_resolve_n.sv
// rtl/branch_resolve_n.sv - EX-stage branch resolution with mispredict redirect and flush
module branch_resolve_n
    import branch_resolve_n_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             valid_i,
    output logic             ready_o,
    input  logic [2:0]       funct3_i,
    input  logic             is_jump_i,
    input  logic [XLEN-1:0]  pc_i,
    input  logic [XLEN-1:0]  imm_i,
    input  logic             pred_taken_i,
    input  logic             br_less_i,
    input  logic             br_equal_i,
    output logic             br_signed_o,
    output logic             resolved_valid_o,
    output logic             resolved_taken_o,
    output logic             redirect_valid_o,
    input  logic             redirect_ready_i,
    output logic [XLEN-1:0]  redirect_pc_o,
    output logic             flush_o,
    output logic [CNT_W-1:0] branch_cnt_o,
    output logic [CNT_W-1:0] mispred_cnt_o
);

    localparam logic [XLEN-1:0] PC_STEP = XLEN'(4);

    state_t          state;
    logic            cond;
    logic            taken;
    logic            mispredict;
    logic            accept;
    logic [XLEN-1:0] target;

    branch_cond_decode u_cond (
        .funct3    (funct3_i),
        .less      (br_less_i),
        .equal     (br_equal_i),
        .cond      (cond),
        .br_signed (br_signed_o)
    );

    assign taken      = is_jump_i | cond;
    assign target     = taken ? (pc_i + imm_i) : (pc_i + PC_STEP);
    assign mispredict = taken ^ pred_taken_i;
    assign ready_o    = (state == IDLE);
    assign accept     = valid_i & (state == IDLE);

    // Resolution FSM: pulses by default, latch redirect on mispredict and hold it until fetch accepts
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state            <= IDLE;
            resolved_valid_o <= 1'b0;
            resolved_taken_o <= 1'b0;
            redirect_valid_o <= 1'b0;
            redirect_pc_o    <= '0;
            flush_o          <= 1'b0;
            branch_cnt_o     <= '0;
            mispred_cnt_o    <= '0;
        end else begin
            resolved_valid_o <= 1'b0;
            flush_o          <= 1'b0;
            case (state)
                IDLE: begin
                    if (accept) begin
                        resolved_valid_o <= 1'b1;
                        resolved_taken_o <= taken;
                        if (branch_cnt_o != '1) begin
                            branch_cnt_o <= branch_cnt_o + 1'b1;
                        end
                        if (mispredict) begin
                            if (mispred_cnt_o != '1) begin
                                mispred_cnt_o <= mispred_cnt_o + 1'b1;
                            end
                            flush_o          <= 1'b1;
                            redirect_valid_o <= 1'b1;
                            redirect_pc_o    <= target;
                            state            <= HOLD;
                        end
                    end
                end
                HOLD: begin
                    if (redirect_valid_o && redirect_ready_i) begin
                        redirect_valid_o <= 1'b0;
                        state            <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_branch_resolve_n.sv
// tb/tb_branch_resolve_n.sv - scoreboard bench for branch_resolve_n
module tb_branch_resolve_n;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        valid_i = 1'b0;
    logic        ready_o;
    logic [2:0]  funct3_i = 3'b000;
    logic        is_jump_i = 1'b0;
    logic [31:0] pc_i = '0;
    logic [31:0] imm_i = '0;
    logic        pred_taken_i = 1'b0;
    logic        br_less_i = 1'b0;
    logic        br_equal_i = 1'b0;
    logic        br_signed_o;
    logic        resolved_valid_o;
    logic        resolved_taken_o;
    logic        redirect_valid_o;
    logic        redirect_ready_i = 1'b0;
    logic [31:0] redirect_pc_o;
    logic        flush_o;
    logic [1:0]  branch_cnt_o;
    logic [1:0]  mispred_cnt_o;

    branch_resolve_n #(.XLEN(32), .CNT_W(2)) dut (
        .clk_i            (clk_i),
        .rst_ni           (rst_ni),
        .valid_i          (valid_i),
        .ready_o          (ready_o),
        .funct3_i         (funct3_i),
        .is_jump_i        (is_jump_i),
        .pc_i             (pc_i),
        .imm_i            (imm_i),
        .pred_taken_i     (pred_taken_i),
        .br_less_i        (br_less_i),
        .br_equal_i       (br_equal_i),
        .br_signed_o      (br_signed_o),
        .resolved_valid_o (resolved_valid_o),
        .resolved_taken_o (resolved_taken_o),
        .redirect_valid_o (redirect_valid_o),
        .redirect_ready_i (redirect_ready_i),
        .redirect_pc_o    (redirect_pc_o),
        .flush_o          (flush_o),
        .branch_cnt_o     (branch_cnt_o),
        .mispred_cnt_o    (mispred_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        taken;
        logic        mis;
        logic [31:0] target;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   errors  = 0;
    int   exp_bcnt = 0;
    int   exp_mcnt = 0;
    bit   exp_hold = 0;

    function automatic logic [1:0] sat2(input int v);
        return (v > 3) ? 2'd3 : 2'(v);
    endfunction

    function automatic exp_t model(input logic [2:0] f3, input logic jmp, input logic [31:0] pc,
                                   input logic [31:0] imm, input logic pred, input logic less,
                                   input logic eq);
        exp_t e;
        logic c;
        case (f3)
            3'd0: c = eq;
            3'd1: c = !eq;
            3'd4, 3'd6: c = less;
            3'd5, 3'd7: c = !less;
            default: c = 1'b0;
        endcase
        e.taken  = jmp || c;
        e.target = e.taken ? pc + imm : pc + 32'd4;
        e.mis    = e.taken != pred;
        return e;
    endfunction

    // Present an op; the bench records what it expects only if the unit should accept it
    task automatic drive(input logic [2:0] f3, input logic jmp, input logic [31:0] pc,
                         input logic [31:0] imm, input logic pred, input logic less,
                         input logic eq);
        exp_t e;
        funct3_i = f3; is_jump_i = jmp; pc_i = pc; imm_i = imm;
        pred_taken_i = pred; br_less_i = less; br_equal_i = eq; valid_i = 1'b1;
        e = model(f3, jmp, pc, imm, pred, less, eq);
        if (!exp_hold) begin
            sb.push_back(e);
            exp_bcnt++;
            if (e.mis) begin
                exp_mcnt++;
                exp_hold = 1;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_ni = 1'b0;
        valid_i = 1'b0;
        redirect_ready_i = 1'b0;
        tick();
        rst_ni = 1'b1;
        sb.delete();
        exp_bcnt = 0;
        exp_mcnt = 0;
        exp_hold = 0;
    endtask

    task automatic test_reset();
        do_reset();
        vectors++;
        if ({resolved_valid_o, resolved_taken_o, redirect_valid_o, flush_o} !== 4'b0 ||
            redirect_pc_o !== 32'h0 || branch_cnt_o !== 2'd0 || mispred_cnt_o !== 2'd0) begin
            errors++;
            $display("FAIL reset_outputs: rv=%b rt=%b rdv=%b fl=%b pc=%h bc=%0d mc=%0d required all 0",
                     resolved_valid_o, resolved_taken_o, redirect_valid_o, flush_o, redirect_pc_o,
                     branch_cnt_o, mispred_cnt_o);
        end
        vectors++;
        if (ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_ready: got %b required 1", ready_o);
        end
    endtask

    task automatic test_beq_correct();
        exp_t e;
        drive(3'b000, 1'b0, 32'h100, 32'h20, 1'b1, 1'b0, 1'b1);
        tick();
        e = sb.pop_front();
        vectors++;
        if (resolved_valid_o !== 1'b1 || resolved_taken_o !== e.taken) begin
            errors++;
            $display("FAIL beq_resolve: rv=%b taken=%b required rv=1 taken=%b",
                     resolved_valid_o, resolved_taken_o, e.taken);
        end
        vectors++;
        if (redirect_valid_o !== 1'b0 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL beq_noredirect: rdv=%b flush=%b required 0 0", redirect_valid_o, flush_o);
        end
        vectors++;
        if (branch_cnt_o !== sat2(exp_bcnt) || mispred_cnt_o !== sat2(exp_mcnt)) begin
            errors++;
            $display("FAIL beq_counters: bc=%0d mc=%0d required %0d %0d",
                     branch_cnt_o, mispred_cnt_o, sat2(exp_bcnt), sat2(exp_mcnt));
        end
    endtask

    task automatic test_bltu_backpressure();
        exp_t e;
        do_reset();
        drive(3'b110, 1'b0, 32'h200, 32'hFFFF_FFF0, 1'b0, 1'b1, 1'b0);
        #1;
        vectors++;
        if (br_signed_o !== 1'b0) begin
            errors++;
            $display("FAIL bltu_signed: got %b required 0", br_signed_o);
        end
        tick();
        e = sb.pop_front();
        vectors++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== e.target || flush_o !== 1'b1 ||
            ready_o !== 1'b0 || resolved_taken_o !== 1'b1) begin
            errors++;
            $display("FAIL bltu_redirect: rdv=%b pc=%h flush=%b ready=%b taken=%b required 1 %h 1 0 1",
                     redirect_valid_o, redirect_pc_o, flush_o, ready_o, resolved_taken_o, e.target);
        end
        // hold for three cycles with an op offered that must be ignored
        for (int i = 0; i < 3; i++) begin
            drive(3'b000, 1'b0, 32'h300, 32'h8, 1'b0, 1'b0, 1'b1);
            tick();
            vectors++;
            if (redirect_valid_o !== 1'b1 || redirect_pc_o !== 32'h1F0 || flush_o !== 1'b0 ||
                resolved_valid_o !== 1'b0 || ready_o !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable[%0d]: rdv=%b pc=%h flush=%b rv=%b ready=%b required 1 1f0 0 0 0",
                         i, redirect_valid_o, redirect_pc_o, flush_o, resolved_valid_o, ready_o);
            end
        end
        redirect_ready_i = 1'b1;
        tick();
        redirect_ready_i = 1'b0;
        exp_hold = 0;
        vectors++;
        if (redirect_valid_o !== 1'b0 || ready_o !== 1'b1 || branch_cnt_o !== sat2(exp_bcnt)) begin
            errors++;
            $display("FAIL handshake_release: rdv=%b ready=%b bc=%0d required 0 1 %0d",
                     redirect_valid_o, ready_o, branch_cnt_o, sat2(exp_bcnt));
        end
    endtask

    task automatic test_bge_wrap();
        exp_t e;
        do_reset();
        redirect_ready_i = 1'b1;
        drive(3'b101, 1'b0, 32'hFFFF_FFFC, 32'h40, 1'b1, 1'b1, 1'b0);
        #1;
        vectors++;
        if (br_signed_o !== 1'b1) begin
            errors++;
            $display("FAIL bge_signed: got %b required 1", br_signed_o);
        end
        tick();
        e = sb.pop_front();
        vectors++;
        if (redirect_valid_o !== 1'b1 || redirect_pc_o !== e.target || resolved_taken_o !== 1'b0) begin
            errors++;
            $display("FAIL bge_wrap: rdv=%b pc=%h taken=%b required 1 %h 0",
                     redirect_valid_o, redirect_pc_o, resolved_taken_o, e.target);
        end
        tick();
        redirect_ready_i = 1'b0;
        exp_hold = 0;
        vectors++;
        if (redirect_valid_o !== 1'b0 || ready_o !== 1'b1 || flush_o !== 1'b0) begin
            errors++;
            $display("FAIL one_cycle_redirect: rdv=%b ready=%b flush=%b required 0 1 0",
                     redirect_valid_o, ready_o, flush_o);
        end
    endtask

    task automatic test_reset_in_hold();
        exp_t e;
        do_reset();
        drive(3'b001, 1'b0, 32'h400, 32'h10, 1'b0, 1'b0, 1'b0);
        tick();
        vectors++;
        if (redirect_valid_o !== 1'b1) begin
            errors++;
            $display("FAIL enter_hold: rdv=%b required 1", redirect_valid_o);
        end
        do_reset();
        vectors++;
        if (redirect_valid_o !== 1'b0 || flush_o !== 1'b0 || resolved_valid_o !== 1'b0 ||
            branch_cnt_o !== 2'd0 || mispred_cnt_o !== 2'd0 || ready_o !== 1'b1) begin
            errors++;
            $display("FAIL reset_hold: rdv=%b fl=%b rv=%b bc=%0d mc=%0d ready=%b required 0 0 0 0 0 1",
                     redirect_valid_o, flush_o, resolved_valid_o, branch_cnt_o, mispred_cnt_o, ready_o);
        end
        drive(3'b100, 1'b0, 32'h500, 32'h8, 1'b0, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        vectors++;
        if (resolved_valid_o !== 1'b1 || resolved_taken_o !== e.taken || redirect_valid_o !== 1'b0 ||
            branch_cnt_o !== sat2(exp_bcnt)) begin
            errors++;
            $display("FAIL after_reset_op: rv=%b taken=%b rdv=%b bc=%0d required 1 %b 0 %0d",
                     resolved_valid_o, resolved_taken_o, redirect_valid_o, branch_cnt_o, e.taken,
                     sat2(exp_bcnt));
        end
    endtask

    task automatic test_back_to_back();
        logic [2:0] codes [4];
        exp_t e;
        codes[0] = 3'b000; codes[1] = 3'b111; codes[2] = 3'b011; codes[3] = 3'b001;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            logic le, eq, pr;
            exp_t m;
            le = 1'($urandom_range(0, 1));
            eq = 1'($urandom_range(0, 1));
            m  = model(codes[i], 1'b0, 32'h600 + 32'(i * 4), 32'h80, 1'b0, le, eq);
            pr = m.taken;
            drive(codes[i], 1'b0, 32'h600 + 32'(i * 4), 32'h80, pr, le, eq);
            tick();
            e = sb.pop_front();
            vectors++;
            if (resolved_valid_o !== 1'b1 || resolved_taken_o !== e.taken || flush_o !== 1'b0 ||
                ready_o !== 1'b1) begin
                errors++;
                $display("FAIL b2b[%0d]: rv=%b taken=%b flush=%b ready=%b required 1 %b 0 1",
                         i, resolved_valid_o, resolved_taken_o, flush_o, ready_o, e.taken);
            end
        end
        drive(3'b010, 1'b1, 32'h700, 32'h100, 1'b1, 1'b0, 1'b0);
        tick();
        e = sb.pop_front();
        vectors++;
        if (resolved_taken_o !== 1'b1 || redirect_valid_o !== 1'b0) begin
            errors++;
            $display("FAIL jump_taken: taken=%b rdv=%b required 1 0", resolved_taken_o, redirect_valid_o);
        end
        vectors++;
        if (branch_cnt_o !== sat2(exp_bcnt)) begin
            errors++;
            $display("FAIL branch_sat: got %0d required %0d", branch_cnt_o, sat2(exp_bcnt));
        end
    endtask

    task automatic test_saturation_illegal();
        exp_t e;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(3'b000, 1'b0, 32'h800, 32'h40, 1'b0, 1'b0, 1'b1);
            tick();
            e = sb.pop_front();
            redirect_ready_i = 1'b1;
            tick();
            redirect_ready_i = 1'b0;
            exp_hold = 0;
        end
        vectors++;
        if (mispred_cnt_o !== 2'd3 || mispred_cnt_o !== sat2(exp_mcnt)) begin
            errors++;
            $display("FAIL mispred_sat: got %0d required 3", mispred_cnt_o);
        end
        drive(3'b010, 1'b0, 32'h900, 32'h40, 1'b0, 1'b1, 1'b1);
        tick();
        e = sb.pop_front();
        vectors++;
        if (resolved_valid_o !== 1'b1 || resolved_taken_o !== 1'b0 || redirect_valid_o !== 1'b0 ||
            flush_o !== 1'b0 || e.taken !== resolved_taken_o) begin
            errors++;
            $display("FAIL illegal_code: rv=%b taken=%b rdv=%b flush=%b required 1 0 0 0",
                     resolved_valid_o, resolved_taken_o, redirect_valid_o, flush_o);
        end
    endtask

    initial begin
        #1;
        test_reset();
        test_beq_correct();
        test_bltu_backpressure();
        test_bge_wrap();
        test_reset_in_hold();
        test_back_to_back();
        test_saturation_illegal();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
